// File: rtl/irda_tx_encoder.sv
// rtl/irda_tx_encoder.sv - IrDA SIR transmit encoder: byte in, 3/16 RZ pulses out
// Optional even-parity bit enabled by defining IRDA_TX_PARITY_EN.
module irda_tx_encoder #(
  parameter int BIT_CYCLES  = 5208,
  parameter int CNT_W       = 13,
  parameter int PULSE_START = (BIT_CYCLES * 7) / 16,
  parameter int PULSE_LEN   = (BIT_CYCLES * 3) / 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ir_tx,
  output logic       busy,
  output logic       byte_done
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PREV  = CNT_W'(BIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] WIN_FIRST = CNT_W'(PULSE_START);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(PULSE_START + PULSE_LEN - 1);

`ifdef IRDA_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_val;
  logic             pulse_next;
`ifdef IRDA_TX_PARITY_EN
  logic             parity_bit;
`endif

  // Accept a byte only in IDLE; held low while reset is asserted.
  assign tx_ready = (state == IDLE) & ~reset;

  // Bit currently on the line and whether the next registered ir_tx is high.
  always_comb begin
    bit_val = 1'b1;
    case (state)
      START:   bit_val = 1'b0;
      DATA:    bit_val = shreg[0];
`ifdef IRDA_TX_PARITY_EN
      PARITY:  bit_val = parity_bit;
`endif
      default: bit_val = 1'b1;
    endcase
    pulse_next = (state != IDLE) && !bit_val &&
                 (cnt >= WIN_FIRST) && (cnt <= WIN_LAST);
  end

  // Frame sequencer: bit-period counter, data shifting and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      ir_tx      <= 1'b0;
      busy       <= 1'b0;
      byte_done  <= 1'b0;
`ifdef IRDA_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      ir_tx     <= pulse_next;
      byte_done <= 1'b0;
      if (state == IDLE) begin
        if (tx_valid && tx_ready) begin
          shreg      <= tx_data;
          cnt        <= '0;
          bit_idx    <= '0;
          busy       <= 1'b1;
          state      <= START;
`ifdef IRDA_TX_PARITY_EN
          parity_bit <= ^tx_data;
`endif
        end
      end else begin
        // byte_done is registered, so it is set one cycle early to land on
        // the final stop-bit cycle.
        if (state == STOP && cnt == CNT_PREV)
          byte_done <= 1'b1;
        if (cnt == CNT_LAST) begin
          cnt <= '0;
          case (state)
            START: state <= DATA;
            DATA: begin
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
`ifdef IRDA_TX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end
`ifdef IRDA_TX_PARITY_EN
            PARITY: state <= STOP;
`endif
            default: begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          endcase
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/irda_tx_encoder.md
Name: irda_tx_encoder

Overview:
- Transmit-side IrDA SIR encoder for the UART/IrDA link.
- Accepts one byte per valid/ready handshake and serialises it as an 8N1 UART frame: start bit, 8 data bits LSB first, stop bit.
- Emits each frame on the IR LED drive as return-to-zero pulses. Every 0 bit produces one high pulse of 3/16 bit period, centred in the bit; every 1 bit produces no pulse.
- Sits between the UART TX byte source and the IR transmitter pin. It is the counterpart of the receive-side bit-period counter.

Parameters:
- BIT_CYCLES, 5208, clock cycles per bit (50 MHz / 9600 baud). Legal values ≥ 16.
- CNT_W, 13, bit-period counter width. Must satisfy 2^CNT_W > BIT_CYCLES.
- PULSE_START, (BIT_CYCLES*7)/16, counter value where the pulse window opens. Integer division; 2278 at default.
- PULSE_LEN, (BIT_CYCLES*3)/16, pulse width in cycles. Integer division; 976 at default.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-high reset
- tx_data  in  8  byte to send; sampled on handshake
- tx_valid  in  1  source has a byte
- tx_ready  out  1  encoder can accept a byte; high only in IDLE
- ir_tx  out  1  IR LED drive, active high, registered
- busy  out  1  high while a frame is in progress (all states except IDLE)
- byte_done  out  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Asserting reset forces, immediately and independent of the clock:
  - state = IDLE, bit counter = 0, bit index = 0
  - ir_tx = 0, busy = 0, byte_done = 0
  - tx_ready = 1 once reset is released
  - Reset mid-frame aborts the frame with no further pulses.
- Handshake: the byte is accepted on the rising edge where tx_valid & tx_ready = 1.
  - tx_data is latched into a shift register; the FSM goes to START.
  - tx_valid while busy is ignored (tx_ready = 0); the source must hold the byte.
- FSM states: IDLE → START → DATA → STOP → IDLE.
  - Each non-IDLE state lasts exactly BIT_CYCLES cycles. The counter runs 0 .. BIT_CYCLES-1, then wraps to 0.
  - DATA repeats 8 times; bit index 0..7, shift right once per bit.
  - STOP → IDLE on counter wrap; byte_done = 1 on that cycle (counter == BIT_CYCLES-1 in STOP).
  - IDLE always lasts at least one cycle between frames. Frame-to-frame period is therefore 10*BIT_CYCLES + 1 cycles.
- Current bit value:
  - START = 0
  - DATA = shift register LSB
  - STOP = 1
- Pulse rule: the next-state value of ir_tx is 1 iff all of the following hold; otherwise 0.
  - state ≠ IDLE
  - current bit value = 0
  - PULSE_START ≤ counter ≤ PULSE_START+PULSE_LEN-1
  
  Because ir_tx is registered, the pulse spans bit-relative cycles PULSE_START+1 .. PULSE_START+PULSE_LEN. The pulse is glitch-free and never straddles a bit boundary.
- Latency: handshake edge = cycle 0.
  - START counter = 0 on cycle 1.
  - First ir_tx rise on cycle 1+PULSE_START+1.
- Counter arithmetic is unsigned CNT_W bits; compare against BIT_CYCLES-1, never rely on natural overflow.
- busy = (state ≠ IDLE); tx_ready = (state == IDLE) & ~reset.

Optional Feature:
- Macro IRDA_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It lasts BIT_CYCLES and carries the even-parity bit (XOR of the 8 data bits), pulsed under the same rule. Frame becomes 11 bits; period 11*BIT_CYCLES + 1.
- Undefined: no PARITY state, no parity logic; 8N1 exactly as above.

Test Plan:
- BIT_CYCLES=16 (PULSE_START=7, PULSE_LEN=3), send 0x55 → 5 pulses, each 3 cycles high (start bit, d1, d3, d5, d7). Pulse in bit k at cycles 16k+9..16k+11 after handshake. byte_done on cycle 160; tx_ready high on cycle 161.
- Same parameters, 0xFF then 0x00 back-to-back, tx_valid held high → 0xFF frame gives 1 pulse; 0x00 accepted on cycle 161 and gives 9 pulses. No pulse is ever wider than 3 cycles.
- tx_valid toggled with a different byte during busy → tx_ready = 0, byte ignored, transmitted pulse pattern unchanged.
- Reset asserted at cycle 40 of a 0x00 frame, while ir_tx = 1 → ir_tx, busy, byte_done drop asynchronously before the next edge. tx_ready = 1 after release; the next handshake starts a fresh START bit.
- Default parameters, send 0xA5 → each pulse 976 cycles, starting 2279 cycles into its bit; total frame 52080 cycles.
- IRDA_TX_PARITY_EN defined, BIT_CYCLES=16:
  - send 0x01 → parity bit 1, no pulse in bit 9; byte_done on cycle 176.
  - send 0x03 → parity bit 0, pulse at cycles 153..155.
